// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) arithmetic, MixColumns coefficient rows and the engine state encoding.
package aes_pkg;

    localparam logic [7:0]  GF_POLY = 8'h1B;
    localparam logic [31:0] MC_FWD  = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [31:0] MC_INV  = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    // Shift-and-add multiply: one xtime per bit of b.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column MixColumns / InvMixColumns; row 0 of the column sits in col_i[31:24].
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        inv_i,
    output logic [31:0] col_o
);

    logic [31:0] coef;

    assign coef = inv_i ? MC_INV : MC_FWD;

    // Row r uses the coefficient row rotated right by r (circulant matrix).
    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                col_o[31-8*r -: 8] = col_o[31-8*r -: 8]
                                   ^ gf_mul(coef[31-8*((k-r)&3) -: 8], col_i[31-8*k -: 8]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequenced MixColumns engine: latches a 128-bit state, transforms COLS_PER_CYCLE columns per clock
// in place, then presents the result until the consumer takes it.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy,
    output state_e       dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and out_state is frozen while out_valid waits.

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    state_e       state_q;
    logic [1:0]   col_cnt_q;
    logic         inv_q;
    logic [127:0] st_q;
    logic [127:0] st_d;

    logic [31:0]  unit_in  [COLS_PER_CYCLE];
    logic [31:0]  unit_out [COLS_PER_CYCLE];

    function automatic logic [6:0] byte_msb(input int r, input logic [1:0] c);
        return 7'(127 - 32*r - 8*int'(c));
    endfunction

    always_comb begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            unit_in[g] = '0;
            for (int r = 0; r < 4; r++) begin
                unit_in[g][31-8*r -: 8] = st_q[byte_msb(r, col_cnt_q + 2'(g)) -: 8];
            end
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        mix_column_unit u_mc (
            .col_i (unit_in[g]),
            .inv_i (inv_q),
            .col_o (unit_out[g])
        );
    end

    // Only the active column group is written back; all other bytes hold.
    always_comb begin
        st_d = st_q;
        case (state_q)
            IDLE: if (in_valid) st_d = in_state;
            RUN: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    for (int r = 0; r < 4; r++) begin
                        st_d[byte_msb(r, col_cnt_q + 2'(g)) -: 8] = unit_out[g][31-8*r -: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            inv_q     <= 1'b0;
            st_q      <= '0;
        end else begin
            st_q <= st_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        inv_q     <= in_inv;
                        col_cnt_q <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    col_cnt_q <= col_cnt_q + STEP;
                    if (col_cnt_q == LAST_CNT) state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_state   = (state_q == DONE) ? st_q : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2 and 4 columns per clock) checked against a
// scoreboard fed by an independent xtime-based reference model.
module tb_mix_columns_seq;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_inv    [3];
    logic [127:0] in_state  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];
    state_e       dbg       [3];

    logic [127:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_inv(in_inv[0]),
        .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_state(out_state[0]), .busy(busy[0]), .dbg_state_o(dbg[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_inv(in_inv[1]),
        .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_state(out_state[1]), .busy(busy[1]), .dbg_state_o(dbg[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_inv(in_inv[2]),
        .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_state(out_state[2]), .busy(busy[2]), .dbg_state_o(dbg[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] m2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] m3(input logic [7:0] x);  return m2(x) ^ x; endfunction
    function automatic logic [7:0] m4(input logic [7:0] x);  return m2(m2(x)); endfunction
    function automatic logic [7:0] m8(input logic [7:0] x);  return m2(m4(x)); endfunction
    function automatic logic [7:0] m9(input logic [7:0] x);  return m8(x) ^ x; endfunction
    function automatic logic [7:0] m11(input logic [7:0] x); return m8(x) ^ m2(x) ^ x; endfunction
    function automatic logic [7:0] m13(input logic [7:0] x); return m8(x) ^ m4(x) ^ x; endfunction
    function automatic logic [7:0] m14(input logic [7:0] x); return m8(x) ^ m4(x) ^ m2(x); endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*c -: 8];
            a1 = s[95-8*c -: 8];
            a2 = s[63-8*c -: 8];
            a3 = s[31-8*c -: 8];
            if (!inv) begin
                o[127-8*c -: 8] = m2(a0) ^ m3(a1) ^ a2 ^ a3;
                o[95-8*c -: 8]  = a0 ^ m2(a1) ^ m3(a2) ^ a3;
                o[63-8*c -: 8]  = a0 ^ a1 ^ m2(a2) ^ m3(a3);
                o[31-8*c -: 8]  = m3(a0) ^ a1 ^ a2 ^ m2(a3);
            end else begin
                o[127-8*c -: 8] = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
                o[95-8*c -: 8]  = m9(a0) ^ m14(a1) ^ m11(a2) ^ m13(a3);
                o[63-8*c -: 8]  = m13(a0) ^ m9(a1) ^ m14(a2) ^ m11(a3);
                o[31-8*c -: 8]  = m11(a0) ^ m13(a1) ^ m9(a2) ^ m14(a3);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] pack_cols(input logic [31:0] c0, input logic [31:0] c1,
                                               input logic [31:0] c2, input logic [31:0] c3);
        logic [127:0] s;
        logic [31:0]  cols [4];
        cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
        s = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[127-32*r-8*c -: 8] = cols[c][31-8*r -: 8];
        return s;
    endfunction

    function automatic int ngrp(input int d);
        case (d)
            0: return 4;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(input int d, input logic [127:0] s, input logic inv, input logic [127:0] exp);
        @(negedge clk);
        total++;
        if (in_ready[d] !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready dut%0d got=%b want=1", d, in_ready[d]);
        end
        in_valid[d] = 1'b1;
        in_state[d] = s;
        in_inv[d]   = inv;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    // Scrambles in_state/in_inv every cycle while waiting, so the result must come from latched inputs.
    task automatic wait_out(input int d);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            in_inv[d]   = ~in_inv[d];
            in_state[d] = rand_state();
            if (out_valid[d] === 1'b1) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat != ngrp(d)) begin
            bad++;
            $display("FAIL latency dut%0d got=%0d want=%0d (0 = timeout)", d, lat, ngrp(d));
        end
    endtask

    task automatic check_out(input int d, output logic [127:0] got);
        logic [127:0] e;
        got = out_state[d];
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty dut%0d got=%h", d, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL out_state dut%0d got=%h want=%h", d, got, e);
            end
        end
    endtask

    task automatic release_out(input int d);
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        total++;
        if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
            bad++;
            $display("FAIL release_idle dut%0d got in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     d, in_ready[d], out_valid[d], busy[d]);
        end
    endtask

    task automatic run_one(input int d, input logic [127:0] s, input logic inv,
                           input logic [127:0] exp, output logic [127:0] got);
        start_op(d, s, inv, exp);
        wait_out(d);
        check_out(d, got);
        release_out(d);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
                out_state[d] !== 128'h0 || dbg[d] !== IDLE) begin
                bad++;
                $display("FAIL reset_values dut%0d got rdy=%b ov=%b busy=%b os=%h st=%0d want 1/0/0/0/IDLE",
                         d, in_ready[d], out_valid[d], busy[d], out_state[d], dbg[d]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_known();
        logic [127:0] x, f, got;
        x = pack_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
        f = pack_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
        for (int d = 0; d < 3; d++) begin
            run_one(d, x, 1'b0, f, got);
            run_one(d, got, 1'b1, x, got);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] x, held, got;
        x = rand_state();
        start_op(1, x, 1'b0, ref_mix(x, 1'b0));
        wait_out(1);
        held = out_state[1];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (out_valid[1] !== 1'b1 || out_state[1] !== held || in_ready[1] !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cycle%0d got ov=%b rdy=%b os=%h want 1/0/%h",
                         i, out_valid[1], in_ready[1], out_state[1], held);
            end
            in_valid[1] = 1'($urandom_range(0, 1));
            in_state[1] = rand_state();
        end
        @(negedge clk);
        in_valid[1] = 1'b0;
        check_out(1, got);
        release_out(1);
        x = rand_state();
        run_one(1, x, 1'b1, ref_mix(x, 1'b1), got);
    endtask

    task automatic test_reset_mid_op();
        logic [127:0] x, got;
        bit stale;
        x = rand_state();
        start_op(0, x, 1'b0, ref_mix(x, 1'b0));
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
            out_state[0] !== 128'h0 || dbg[0] !== IDLE) begin
            bad++;
            $display("FAIL reset_mid_op got rdy=%b ov=%b busy=%b os=%h st=%0d want 1/0/0/0/IDLE",
                     in_ready[0], out_valid[0], busy[0], out_state[0], dbg[0]);
        end
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++;
            $display("FAIL stale_after_reset got activity=1 want 0");
        end
        x = rand_state();
        run_one(0, x, 1'b0, ref_mix(x, 1'b0), got);
    endtask

    task automatic test_random();
        logic [127:0] x, f, back;
        int d;
        for (int i = 0; i < 1000; i++) begin
            d = i % 3;
            x = rand_state();
            run_one(d, x, 1'b0, ref_mix(x, 1'b0), f);
            run_one(d, f, 1'b1, ref_mix(f, 1'b1), back);
            total++;
            if (back !== x) begin
                bad++;
                $display("FAIL roundtrip iter%0d dut%0d got=%h want=%h", i, d, back, x);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_inv[d]    = 1'b0;
            in_state[d]  = '0;
            out_ready[d] = 1'b0;
        end
        test_reset();
        test_known();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
